// File: rtl/stopwatch_control.sv
// rtl/stopwatch_control.sv - start/stop/lap/clear sequencing for the 0.00.0 stopwatch chain
module stopwatch_control (
    input  logic       clk,
    input  logic       reset,
    input  logic       startStop,
    input  logic       lap,
    input  logic       clear,
    input  logic       upSwitch,
    input  logic       tick,
    input  logic [3:0] minute,
    input  logic [3:0] tenSecond,
    input  logic [3:0] oneSecond,
    input  logic [3:0] tenthSecond,
    output logic       countEnable,
    output logic       countUp,
    output logic       counterClear,
    output logic [3:0] dispMinute,
    output logic [3:0] dispTenSecond,
    output logic [3:0] dispOneSecond,
    output logic [3:0] dispTenthSecond,
    output logic       running,
    output logic       lapActive,
    output logic       done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] LAP   = 3'd2;
    localparam logic [2:0] PAUSE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0] state;
    logic       dir_reg;
    logic [3:0] lap_minute;
    logic [3:0] lap_ten_second;
    logic [3:0] lap_one_second;
    logic [3:0] lap_tenth_second;
    logic       term;
    logic       unused_tick;

    // The tick only advances the chain; gating here is on the digits alone.
    assign unused_tick = tick;

    always_comb begin
        term = 1'b0;
        if (dir_reg) begin
            term = (minute == 4'd9) && (tenSecond == 4'd5) &&
                   (oneSecond == 4'd9) && (tenthSecond == 4'd9);
        end else begin
            term = (minute == 4'd0) && (tenSecond == 4'd0) &&
                   (oneSecond == 4'd0) && (tenthSecond == 4'd0);
        end
    end

    assign running     = (state == RUN) || (state == LAP);
    assign lapActive   = (state == LAP);
    assign done        = (state == DONE);
    assign countUp     = dir_reg;
    // Combinational so the chain freezes on the terminal value without wrapping.
    assign countEnable = running && !term;

    assign dispMinute      = lapActive ? lap_minute       : minute;
    assign dispTenSecond   = lapActive ? lap_ten_second   : tenSecond;
    assign dispOneSecond   = lapActive ? lap_one_second   : oneSecond;
    assign dispTenthSecond = lapActive ? lap_tenth_second : tenthSecond;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            dir_reg          <= 1'b1;
            lap_minute       <= 4'd0;
            lap_ten_second   <= 4'd0;
            lap_one_second   <= 4'd0;
            lap_tenth_second <= 4'd0;
            counterClear     <= 1'b0;
        end else begin
            counterClear <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        counterClear <= 1'b1;
                    end else if (startStop) begin
                        dir_reg <= upSwitch;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (term) begin
                        state <= DONE;
                    end else if (startStop) begin
                        state <= PAUSE;
                    end else if (lap) begin
                        lap_minute       <= minute;
                        lap_ten_second   <= tenSecond;
                        lap_one_second   <= oneSecond;
                        lap_tenth_second <= tenthSecond;
                        state            <= LAP;
                    end
                end
                LAP: begin
                    if (term) begin
                        state <= DONE;
                    end else if (startStop) begin
                        state <= PAUSE;
                    end else if (lap) begin
                        state <= RUN;
                    end
                end
                PAUSE: begin
                    if (clear) begin
                        counterClear <= 1'b1;
                        state        <= IDLE;
                    end else if (startStop) begin
                        dir_reg <= upSwitch;
                        state   <= RUN;
                    end
                end
                DONE: begin
                    if (clear) begin
                        counterClear <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
